trap_ctrl: RTL and testbench

- Machine-mode trap/interrupt controller sitting beside the instruction decoder at the commit point.
- Consumes decoded WFI/MRET flags, CSR index/write requests and external/timer interrupt lines.
- Owns mstatus/mie/mip/mepc/mcause/mtvec and sequences trap entry, MRET return and WFI sleep.
- Drives a registered PC redirect/flush and a WFI stall into the pipeline.

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_ctrl_if.sv | 32 +++
 rtl/trap_csr_regs.sv | 120 ++++++++++++
 rtl/trap_ctrl.sv | 119 +++++++++++
 tb/tb_trap_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller:
// CSR addresses, register bit positions, cause codes and FSM states.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  // MPP is hardwired to machine mode, so these bits always read as 1.
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-point interface between the pipeline (master) and the trap
// controller (slave): instruction flags, CSR access, interrupts, redirect.
interface trap_ctrl_if;

  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        is_wfi;
  logic        is_mret;
  logic        csr_we;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        stall_in;
  logic        irq_ext;
  logic        irq_timer;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wfi_stall;

  modport master (
    output inst_valid, inst_pc, is_wfi, is_mret, csr_we, csr_idx, csr_wdata,
    output stall_in, irq_ext, irq_timer,
    input  csr_rdata, redirect_valid, redirect_pc, wfi_stall
  );

  modport slave (
    input  inst_valid, inst_pc, is_wfi, is_mret, csr_we, csr_idx, csr_wdata,
    input  stall_in, irq_ext, irq_timer,
    output csr_rdata, redirect_valid, redirect_pc, wfi_stall
  );

endinterface

// File: rtl/trap_csr_regs.sv
// Machine-mode CSR storage: masked writes, trap-entry and MRET updates of
// mstatus/mepc/mcause, and the combinational CSR read mux.
module trap_csr_regs
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [11:0] csr_idx_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        trap_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] csr_rdata_o,
  output logic        mstatus_mie_o,
  output logic        mie_meie_o,
  output logic        mie_mtie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q,     mie_meie_d;
  logic        mie_mtie_q,     mie_mtie_d;
  logic [31:0] mtvec_q,        mtvec_d;
  logic [31:0] mepc_q,         mepc_d;
  logic [31:0] mcause_q,       mcause_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (trap_i) begin
      mepc_d         = trap_epc_i;
      mcause_d       = trap_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we_i) begin
      case (csr_idx_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata_i[MSTATUS_MIE];
          mstatus_mpie_d = csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          mie_meie_d = csr_wdata_i[MIE_MEIE];
          mie_mtie_d = csr_wdata_i[MIE_MTIE];
        end
        CSR_MTVEC:  mtvec_d  = {csr_wdata_i[31:2], 2'b00};
        CSR_MEPC:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_idx_i)
      CSR_MSTATUS: begin
        csr_rdata_o               = MSTATUS_FIXED;
        csr_rdata_o[MSTATUS_MIE]  = mstatus_mie_q;
        csr_rdata_o[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE: begin
        csr_rdata_o[MIE_MEIE] = mie_meie_q;
        csr_rdata_o[MIE_MTIE] = mie_mtie_q;
      end
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MIP: begin
        csr_rdata_o[MIE_MEIE] = irq_ext_i;
        csr_rdata_o[MIE_MTIE] = irq_timer_i;
      end
      default: ;
    endcase
  end

  assign mstatus_mie_o = mstatus_mie_q;
  assign mie_meie_o    = mie_meie_q;
  assign mie_mtie_o    = mie_mtie_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Commit-point trap controller: RUN/SLEEP FSM, trap/MRET/WFI/CSR priority
// and the registered one-cycle PC redirect pulse.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] wfi_pc_q, wfi_pc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        mstatus_mie, mie_meie, mie_mtie;
  logic [31:0] mtvec, mepc;
  logic        pend_ext, pend_tmr, pend, accept;
  logic        trap_fire, mret_fire, wfi_fire, csr_wr;
  logic [31:0] trap_epc, trap_cause;
  logic        wfi_stall;

  assign pend_ext   = mie_meie & bus.irq_ext;
  assign pend_tmr   = mie_mtie & bus.irq_timer;
  assign pend       = pend_ext | pend_tmr;
  assign trap_cause = pend_ext ? MCAUSE_MEI : MCAUSE_MTI;
  // Anything presented alongside a redirect pulse is a flushed younger instruction.
  assign accept     = bus.inst_valid & ~bus.stall_in & ~redirect_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      wfi_pc_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      wfi_pc_q         <= wfi_pc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Sleep ends on any enabled pending interrupt, whether or not MIE allows a trap.
  always_comb begin
    state_d          = state_q;
    wfi_pc_d         = wfi_pc_q;
    redirect_valid_d = trap_fire | mret_fire;
    redirect_pc_d    = redirect_pc_q;
    unique case (state_q)
      RUN: begin
        if (wfi_fire) begin
          state_d  = SLEEP;
          wfi_pc_d = bus.inst_pc + 32'd4;
        end
      end
      SLEEP: if (pend) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (trap_fire)      redirect_pc_d = mtvec;
    else if (mret_fire) redirect_pc_d = mepc;
  end

  always_comb begin
    trap_fire = 1'b0;
    mret_fire = 1'b0;
    wfi_fire  = 1'b0;
    csr_wr    = 1'b0;
    trap_epc  = bus.inst_pc;
    wfi_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (mstatus_mie & pend) trap_fire = 1'b1;
          else if (bus.is_mret)   mret_fire = 1'b1;
          else if (bus.is_wfi)    wfi_fire  = 1'b1;
          else if (bus.csr_we)    csr_wr    = 1'b1;
        end
      end
      SLEEP: begin
        wfi_stall = 1'b1;
        if (pend & mstatus_mie) begin
          trap_fire = 1'b1;
          trap_epc  = wfi_pc_q;
        end
      end
      default: ;
    endcase
  end

  trap_csr_regs #(
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_we_i      (csr_wr),
    .csr_idx_i     (bus.csr_idx),
    .csr_wdata_i   (bus.csr_wdata),
    .irq_ext_i     (bus.irq_ext),
    .irq_timer_i   (bus.irq_timer),
    .trap_i        (trap_fire),
    .trap_epc_i    (trap_epc),
    .trap_cause_i  (trap_cause),
    .mret_i        (mret_fire),
    .csr_rdata_o   (bus.csr_rdata),
    .mstatus_mie_o (mstatus_mie),
    .mie_meie_o    (mie_meie),
    .mie_mtie_o    (mie_mtie),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.wfi_stall      = wfi_stall;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected redirects and CSR reads are queued
// by the stimulus and compared by a negedge monitor when the DUT presents them.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl #(
    .MTVEC_RESET (32'h0000_0203)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_redir_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic        rd_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rd_strobe && exp_rd_q.size() > 0)
      check(rd_name_q.pop_front(), bus.csr_rdata, exp_rd_q.pop_front());
    if (rst_n === 1'b1 && bus.redirect_valid !== 1'b0) begin
      if (exp_redir_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_redirect: got redirect_valid=%b pc=0x%08h, required no redirect",
                 bus.redirect_valid, bus.redirect_pc);
      end else begin
        check("redirect_pc", bus.redirect_pc, exp_redir_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_valid = 1'b0;
    bus.is_wfi     = 1'b0;
    bus.is_mret    = 1'b0;
    bus.csr_we     = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic wfi, input logic mret,
                        input logic we, input logic [11:0] idx, input logic [31:0] wd);
    bus.inst_valid = 1'b1;
    bus.inst_pc    = pc;
    bus.is_wfi     = wfi;
    bus.is_mret    = mret;
    bus.csr_we     = we;
    bus.csr_idx    = idx;
    bus.csr_wdata  = wd;
    step();
    idle_inputs();
  endtask

  task automatic csr_write(input logic [11:0] idx, input logic [31:0] wd);
    commit(32'h0000_1000, 1'b0, 1'b0, 1'b1, idx, wd);
  endtask

  task automatic csr_read(input string name, input logic [11:0] idx, input logic [31:0] exp);
    bus.csr_idx = idx;
    rd_name_q.push_back(name);
    exp_rd_q.push_back(exp);
    rd_strobe = 1'b1;
    step();
    rd_strobe = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    idle_inputs();
    bus.inst_pc   = '0;
    bus.csr_idx   = '0;
    bus.csr_wdata = '0;
    bus.stall_in  = 1'b0;
    bus.irq_ext   = 1'b0;
    bus.irq_timer = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    csr_read("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    csr_read("rst_mtvec",   CSR_MTVEC,   32'h0000_0200);
    csr_read("rst_mie",     CSR_MIE,     32'h0000_0000);
    csr_read("rst_mepc",    CSR_MEPC,    32'h0000_0000);
    csr_read("rst_mcause",  CSR_MCAUSE,  32'h0000_0000);
    csr_read("unknown_csr", 12'h7C0,     32'h0000_0000);
    check("rst_wfi_stall", {31'd0, bus.wfi_stall}, 32'd0);

    // CSR write masking
    csr_write(CSR_MTVEC, 32'h0000_0103);
    csr_read("mtvec_mask", CSR_MTVEC, 32'h0000_0100);
    csr_write(CSR_MIE, 32'hFFFF_FFFF);
    csr_read("mie_mask", CSR_MIE, 32'h0000_0880);
    csr_write(CSR_MIE, 32'h0000_0800);
    csr_write(CSR_MIP, 32'hFFFF_FFFF);
    csr_read("mip_readonly", CSR_MIP, 32'h0000_0000);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
    csr_read("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    csr_read("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);

    // External interrupt trap; the trapped CSR write and a flushed follower are dropped
    bus.irq_ext = 1'b1;
    csr_read("mip_ext", CSR_MIP, 32'h0000_0800);
    exp_redir_q.push_back(32'h0000_0100);
    commit(32'h0000_0040, 1'b0, 1'b0, 1'b1, CSR_MEPC, 32'h0000_DEAC);
    csr_write(CSR_MEPC, 32'h0000_0998);
    bus.irq_ext = 1'b0;
    csr_read("trap_mepc",    CSR_MEPC,    32'h0000_0040);
    csr_read("trap_mcause",  CSR_MCAUSE,  32'h8000_000B);
    csr_read("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // MRET returns to mepc
    exp_redir_q.push_back(32'h0000_0040);
    commit(32'h0000_0100, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0);
    csr_read("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // WFI, sleep, timer wake with MIE=1 -> trap with mepc = wfi pc + 4
    csr_write(CSR_MIE, 32'h0000_0080);
    commit(32'h0000_0080, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("sleep_stall", {31'd0, bus.wfi_stall}, 32'd1);
      step();
    end
    bus.irq_timer = 1'b1;
    exp_redir_q.push_back(32'h0000_0100);
    step();
    check("wake_trap_stall", {31'd0, bus.wfi_stall}, 32'd0);
    bus.irq_timer = 1'b0;
    step();
    csr_read("wfi_mepc",    CSR_MEPC,    32'h0000_0084);
    csr_read("wfi_mcause",  CSR_MCAUSE,  32'h8000_0007);
    csr_read("wfi_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // WFI wake with MIE=0: resume, no redirect, mepc unchanged
    csr_write(CSR_MIE, 32'h0000_0800);
    commit(32'h0000_0200, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    check("sleep2_stall", {31'd0, bus.wfi_stall}, 32'd1);
    csr_write(CSR_MEPC, 32'h0000_0555);
    bus.irq_ext = 1'b1;
    step();
    check("wake_nomie_stall", {31'd0, bus.wfi_stall}, 32'd0);
    bus.irq_ext = 1'b0;
    step();
    csr_read("nomie_mepc",    CSR_MEPC,    32'h0000_0084);
    csr_read("nomie_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // stall_in defers both pending interrupts; external wins when released
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    csr_write(CSR_MIE, 32'h0000_0880);
    bus.irq_ext    = 1'b1;
    bus.irq_timer  = 1'b1;
    bus.stall_in   = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst_pc    = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    end
    exp_redir_q.push_back(32'h0000_0100);
    bus.stall_in = 1'b0;
    step();
    idle_inputs();
    bus.irq_ext   = 1'b0;
    bus.irq_timer = 1'b0;
    step();
    csr_read("prio_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_read("prio_mepc",   CSR_MEPC,   32'h0000_0300);

    // WFI with pend already true (MIE=0): exactly one sleep cycle
    bus.irq_timer = 1'b1;
    commit(32'h0000_0400, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    check("pend_wfi_sleep", {31'd0, bus.wfi_stall}, 32'd1);
    step();
    check("pend_wfi_wake", {31'd0, bus.wfi_stall}, 32'd0);
    bus.irq_timer = 1'b0;
    step();

    // Reset while sleeping drops wfi_stall immediately
    commit(32'h0000_0500, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    check("rst_sleep_before", {31'd0, bus.wfi_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sleep_stall", {31'd0, bus.wfi_stall}, 32'd0);
    check("rst_sleep_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    csr_read("rst2_mstatus", CSR_MSTATUS, 32'h0000_1800);
    csr_read("rst2_mtvec",   CSR_MTVEC,   32'h0000_0200);
    csr_read("rst2_mepc",    CSR_MEPC,    32'h0000_0000);

    step();
    check("redirect_queue_drained", exp_redir_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
